// File: rtl/reg_file_rename.sv
// Architectural register file with per-register ROB rename tags.
// Serves decoder operand reads combinationally and absorbs ROB allocate/commit traffic.
module reg_file_rename #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ROB_W = 4,
  parameter int unsigned NREG  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic [ROB_W-1:0] rs1_ROB_pos,
  output logic [ROB_W-1:0] rs2_ROB_pos,
  output logic [XLEN-1:0]  rs1_val,
  output logic [XLEN-1:0]  rs2_val,
  input  logic             update_ROB_valid,
  input  logic [ROB_W-1:0] update_ROB_pos,
  input  logic [4:0]       update_ROB_rd,
  input  logic             commit_valid,
  input  logic [ROB_W-1:0] commit_ROB_pos,
  input  logic [4:0]       commit_rd,
  input  logic [XLEN-1:0]  new_val
);

  logic [XLEN-1:0]  val_q [NREG];
  logic [XLEN-1:0]  val_d [NREG];
  logic [ROB_W-1:0] tag_q [NREG];
  logic [ROB_W-1:0] tag_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;

  logic commit_en, update_en;

  assign commit_en = commit_valid && (commit_rd != 5'd0);
  assign update_en = update_ROB_valid && (update_ROB_rd != 5'd0);

  // Commit first, then update/flush so a same-cycle rename of the committed register wins.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (commit_en) begin
      val_d[commit_rd] = new_val;
      if (tag_q[commit_rd] == commit_ROB_pos) begin
        busy_d[commit_rd] = 1'b0;
      end
    end
    if (flush) begin
      busy_d = '0;
    end else if (update_en) begin
      busy_d[update_ROB_rd] = 1'b1;
      tag_d[update_ROB_rd]  = update_ROB_pos;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (rdy) begin
      busy_q <= busy_d;
      for (int i = 0; i < int'(NREG); i++) begin
        val_q[i] <= val_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // A commit that retires the current producer is forwarded in the same cycle.
  always_comb begin
    rs1_busy    = busy_q[rs1];
    rs1_ROB_pos = tag_q[rs1];
    rs1_val     = val_q[rs1];
    if (busy_q[rs1] && commit_valid && (commit_rd == rs1) && (commit_ROB_pos == tag_q[rs1])) begin
      rs1_busy = 1'b0;
      rs1_val  = new_val;
    end
  end

  always_comb begin
    rs2_busy    = busy_q[rs2];
    rs2_ROB_pos = tag_q[rs2];
    rs2_val     = val_q[rs2];
    if (busy_q[rs2] && commit_valid && (commit_rd == rs2) && (commit_ROB_pos == tag_q[rs2])) begin
      rs2_busy = 1'b0;
      rs2_val  = new_val;
    end
  end

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed self-checking bench for reg_file_rename: rename, commit, forwarding, stale tags,
// x0, rdy freeze, flush and reset.
module tb_reg_file_rename;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_ROB_pos, rs2_ROB_pos;
  logic [31:0] rs1_val, rs2_val;
  logic        update_ROB_valid;
  logic [3:0]  update_ROB_pos;
  logic [4:0]  update_ROB_rd;
  logic        commit_valid;
  logic [3:0]  commit_ROB_pos;
  logic [4:0]  commit_rd;
  logic [31:0] new_val;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_rename #(.XLEN(32), .ROB_W(4), .NREG(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .flush            (flush),
    .rs1              (rs1),
    .rs2              (rs2),
    .rs1_busy         (rs1_busy),
    .rs2_busy         (rs2_busy),
    .rs1_ROB_pos      (rs1_ROB_pos),
    .rs2_ROB_pos      (rs2_ROB_pos),
    .rs1_val          (rs1_val),
    .rs2_val          (rs2_val),
    .update_ROB_valid (update_ROB_valid),
    .update_ROB_pos   (update_ROB_pos),
    .update_ROB_rd    (update_ROB_rd),
    .commit_valid     (commit_valid),
    .commit_ROB_pos   (commit_ROB_pos),
    .commit_rd        (commit_rd),
    .new_val          (new_val)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; flush = 1'b0;
    update_ROB_valid = 1'b0; update_ROB_pos = '0; update_ROB_rd = '0;
    commit_valid = 1'b0; commit_ROB_pos = '0; commit_rd = '0; new_val = '0;
  endtask

  // Inputs change #1 after the edge; checks happen a further #1 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [4:0] rd, input logic [3:0] pos);
    update_ROB_valid = 1'b1; update_ROB_rd = rd; update_ROB_pos = pos;
    tick();
    idle();
  endtask

  task automatic chk_rs1(input string name, input logic b, input logic [3:0] p, input logic chk_p,
                         input logic [31:0] v, input logic chk_v);
    #1;
    n_checks++;
    if (rs1_busy !== b) begin
      n_fail++; $display("FAIL %s rs1_busy: got %0b want %0b", name, rs1_busy, b);
    end
    if (chk_p) begin
      n_checks++;
      if (rs1_ROB_pos !== p) begin
        n_fail++; $display("FAIL %s rs1_ROB_pos: got %0d want %0d", name, rs1_ROB_pos, p);
      end
    end
    if (chk_v) begin
      n_checks++;
      if (rs1_val !== v) begin
        n_fail++; $display("FAIL %s rs1_val: got %h want %h", name, rs1_val, v);
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; rdy = 1'b0;
    tick();
    idle();
    rs1 = 5'd5; rs2 = 5'd0;
    #1;
    n_checks += 4;
    if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL reset rs1_busy: got %0b want 0", rs1_busy); end
    if (rs1_val !== 32'h0) begin n_fail++; $display("FAIL reset rs1_val: got %h want 0", rs1_val); end
    if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL reset rs2_busy: got %0b want 0", rs2_busy); end
    if (rs2_val !== 32'h0) begin n_fail++; $display("FAIL reset rs2_val: got %h want 0", rs2_val); end
    n_checks++;
    if (rs1_ROB_pos !== 4'd0) begin n_fail++; $display("FAIL reset rs1_ROB_pos: got %0d want 0", rs1_ROB_pos); end
  endtask

  task automatic test_rename_commit();
    do_update(5'd3, 4'd7);
    rs1 = 5'd3; rs2 = 5'd3;
    chk_rs1("rename", 1'b1, 4'd7, 1'b1, 32'h0, 1'b0);
    n_checks++;
    if (rs2_busy !== 1'b1 || rs2_ROB_pos !== 4'd7) begin
      n_fail++; $display("FAIL rename rs2: got busy %0b pos %0d want busy 1 pos 7", rs2_busy, rs2_ROB_pos);
    end
    commit_valid = 1'b1; commit_rd = 5'd3; commit_ROB_pos = 4'd7; new_val = 32'h1234;
    chk_rs1("commit_fwd", 1'b0, 4'd0, 1'b0, 32'h1234, 1'b1);
    n_checks++;
    if (rs2_busy !== 1'b0 || rs2_val !== 32'h1234) begin
      n_fail++; $display("FAIL commit_fwd rs2: got busy %0b val %h want busy 0 val 1234", rs2_busy, rs2_val);
    end
    tick();
    idle();
    chk_rs1("commit_after", 1'b0, 4'd0, 1'b0, 32'h1234, 1'b1);
    // Same-cycle rename must not be visible to the read.
    update_ROB_valid = 1'b1; update_ROB_rd = 5'd5; update_ROB_pos = 4'd1; rs1 = 5'd5;
    chk_rs1("upd_invisible", 1'b0, 4'd0, 1'b0, 32'h0, 1'b1);
    tick();
    idle();
    chk_rs1("upd_visible", 1'b1, 4'd1, 1'b1, 32'h0, 1'b1);
  endtask

  task automatic test_stale_commit();
    do_update(5'd4, 4'd2);
    do_update(5'd4, 4'd9);
    rs1 = 5'd4;
    commit_valid = 1'b1; commit_rd = 5'd4; commit_ROB_pos = 4'd2; new_val = 32'hAA;
    chk_rs1("stale_same", 1'b1, 4'd9, 1'b1, 32'h0, 1'b1);
    tick();
    idle();
    chk_rs1("stale_after", 1'b1, 4'd9, 1'b1, 32'hAA, 1'b1);
    commit_valid = 1'b1; commit_rd = 5'd4; commit_ROB_pos = 4'd9; new_val = 32'hBB;
    chk_rs1("young_fwd", 1'b0, 4'd0, 1'b0, 32'hBB, 1'b1);
    tick();
    idle();
    chk_rs1("young_after", 1'b0, 4'd0, 1'b0, 32'hBB, 1'b1);
  endtask

  task automatic test_commit_update_same();
    do_update(5'd6, 4'd1);
    rs1 = 5'd6;
    commit_valid = 1'b1; commit_rd = 5'd6; commit_ROB_pos = 4'd1; new_val = 32'h55;
    update_ROB_valid = 1'b1; update_ROB_rd = 5'd6; update_ROB_pos = 4'd12;
    chk_rs1("cu_same_fwd", 1'b0, 4'd0, 1'b0, 32'h55, 1'b1);
    tick();
    idle();
    chk_rs1("cu_same_after", 1'b1, 4'd12, 1'b1, 32'h55, 1'b1);
  endtask

  task automatic test_x0();
    rs1 = 5'd0;
    update_ROB_valid = 1'b1; update_ROB_rd = 5'd0; update_ROB_pos = 4'd3;
    commit_valid = 1'b1; commit_rd = 5'd0; commit_ROB_pos = 4'd3; new_val = 32'hFFFF;
    chk_rs1("x0_same", 1'b0, 4'd0, 1'b0, 32'h0, 1'b1);
    tick();
    idle();
    chk_rs1("x0_after", 1'b0, 4'd0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_rdy_flush();
    do_update(5'd3, 4'd10);
    do_update(5'd4, 4'd11);
    // Frozen: update, commit and flush all ignored, but forwarding still visible.
    rdy = 1'b0; flush = 1'b1;
    update_ROB_valid = 1'b1; update_ROB_rd = 5'd8; update_ROB_pos = 4'd5;
    commit_valid = 1'b1; commit_rd = 5'd3; commit_ROB_pos = 4'd10; new_val = 32'h77;
    rs1 = 5'd3;
    chk_rs1("rdy0_fwd", 1'b0, 4'd0, 1'b0, 32'h77, 1'b1);
    tick();
    idle();
    rs1 = 5'd8;
    chk_rs1("rdy0_no_upd", 1'b0, 4'd0, 1'b0, 32'h0, 1'b1);
    rs1 = 5'd3;
    chk_rs1("rdy0_no_commit", 1'b1, 4'd10, 1'b1, 32'h1234, 1'b1);
    // Flush with a commit (value lands) and an update (discarded).
    flush = 1'b1;
    commit_valid = 1'b1; commit_rd = 5'd3; commit_ROB_pos = 4'd0; new_val = 32'h99;
    update_ROB_valid = 1'b1; update_ROB_rd = 5'd9; update_ROB_pos = 4'd2;
    tick();
    idle();
    rs1 = 5'd3; rs2 = 5'd4;
    chk_rs1("flush_r3", 1'b0, 4'd0, 1'b0, 32'h99, 1'b1);
    n_checks++;
    if (rs2_busy !== 1'b0 || rs2_val !== 32'hBB) begin
      n_fail++; $display("FAIL flush_r4: got busy %0b val %h want busy 0 val bb", rs2_busy, rs2_val);
    end
    rs1 = 5'd6; rs2 = 5'd9;
    chk_rs1("flush_r6", 1'b0, 4'd0, 1'b0, 32'h55, 1'b1);
    n_checks++;
    if (rs2_busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_r9: got busy %0b want 0", rs2_busy);
    end
    rs1 = 5'd5;
    chk_rs1("flush_r5", 1'b0, 4'd0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_back_to_back();
    update_ROB_valid = 1'b1; update_ROB_rd = 5'd10; update_ROB_pos = 4'd3;
    tick();
    update_ROB_valid = 1'b1; update_ROB_rd = 5'd11; update_ROB_pos = 4'd4;
    commit_valid = 1'b1; commit_rd = 5'd10; commit_ROB_pos = 4'd3; new_val = 32'hA0;
    tick();
    idle();
    rs1 = 5'd10; rs2 = 5'd11;
    chk_rs1("b2b_r10", 1'b0, 4'd0, 1'b0, 32'hA0, 1'b1);
    n_checks++;
    if (rs2_busy !== 1'b1 || rs2_ROB_pos !== 4'd4) begin
      n_fail++; $display("FAIL b2b_r11: got busy %0b pos %0d want busy 1 pos 4", rs2_busy, rs2_ROB_pos);
    end
  endtask

  task automatic test_reset_again();
    rst = 1'b1; rdy = 1'b0;
    tick();
    idle();
    rs1 = 5'd11; rs2 = 5'd10;
    chk_rs1("rst2_r11", 1'b0, 4'd0, 1'b1, 32'h0, 1'b1);
    n_checks++;
    if (rs2_val !== 32'h0) begin
      n_fail++; $display("FAIL rst2_r10: got val %h want 0", rs2_val);
    end
  endtask

  initial begin
    idle();
    rs1 = '0; rs2 = '0;
    #2;
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_commit_update_same();
    test_x0();
    test_rdy_flush();
    test_back_to_back();
    test_reset_again();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
